// File: rtl/baud_gen_frac.sv
// Fractional-divisor UART baud generator: oversample tick plus bit-rate tick,
// with a shadowed divisor that is applied only on a bit boundary.
module baud_gen_frac #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OSR          = 16,
    parameter int RST_DIV_INT  = 27,
    parameter int RST_DIV_FRAC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tick_os,
    output logic              baud_tick,
    output logic              cfg_pending
);

    localparam int OS_W = (OSR > 2) ? $clog2(OSR) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);

    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [DIV_W-1:0]  shd_int;
    logic [FRAC_W-1:0] shd_frac;
    logic [DIV_W:0]    cnt;
    logic [FRAC_W-1:0] acc;
    logic              carry;
    logic [OS_W-1:0]   os_cnt;

    logic [DIV_W:0]    len;
    logic [FRAC_W:0]   acc_sum;
    logic              period_done;
    logic              is_baud;
    logic              apply;

    // Divisors below 2 cannot produce distinct pulses, so they are clamped to 2.
    function automatic logic [DIV_W:0] eff_len(input logic [DIV_W-1:0] d, input logic c);
        logic [DIV_W:0] base;
        base = (d < DIV_W'(2)) ? (DIV_W+1)'(2) : {1'b0, d};
        return base + {{DIV_W{1'b0}}, c};
    endfunction

    always_comb begin
        len         = eff_len(act_int, carry);
        acc_sum     = {1'b0, acc} + {1'b0, act_frac};
        period_done = enable && (cnt == len - 1'b1);
        is_baud     = period_done && (os_cnt == OS_LAST);
        apply       = cfg_pending && (is_baud || !enable);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_int     <= DIV_W'(RST_DIV_INT);
            act_frac    <= FRAC_W'(RST_DIV_FRAC);
            shd_int     <= '0;
            shd_frac    <= '0;
            cnt         <= '0;
            acc         <= '0;
            carry       <= 1'b0;
            os_cnt      <= '0;
            tick_os     <= 1'b0;
            baud_tick   <= 1'b0;
            cfg_pending <= 1'b0;
        end else begin
            tick_os   <= 1'b0;
            baud_tick <= 1'b0;
            if (!enable) begin
                cnt    <= '0;
                acc    <= '0;
                carry  <= 1'b0;
                os_cnt <= '0;
            end else if (period_done) begin
                cnt            <= '0;
                tick_os        <= 1'b1;
                {carry, acc}   <= acc_sum;
                if (is_baud) begin
                    baud_tick <= 1'b1;
                    os_cnt    <= '0;
                end else begin
                    os_cnt <= os_cnt + 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A newly applied divisor starts with a clean fractional phase.
            if (apply) begin
                act_int  <= shd_int;
                act_frac <= shd_frac;
                acc      <= '0;
                carry    <= 1'b0;
            end

            // A load landing on the applying edge stays queued for the next boundary.
            if (load) begin
                shd_int     <= div_int;
                shd_frac    <= div_frac;
                cfg_pending <= 1'b1;
            end else if (apply) begin
                cfg_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: directed scenarios plus a randomized phase, all checked
// each cycle against a period-arithmetic reference model.
module tb_baud_gen_frac;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OSR    = 16;
    localparam int FR     = 1 << FRAC_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              load;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              tick_os;
    logic              baud_tick;
    logic              cfg_pending;

    baud_gen_frac #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR),
                    .RST_DIV_INT(27), .RST_DIV_FRAC(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .div_int(div_int), .div_frac(div_frac),
        .tick_os(tick_os), .baud_tick(baud_tick), .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    // Reference model: period k after a restart lasts d + floor((k-1)f/2^F) - floor((k-2)f/2^F).
    int m_d, m_f, s_d, s_f, m_el, m_n, m_tk;
    bit m_pend, m_apply, e_tick, e_baud;

    function automatic int plen(int n, int d, int f);
        int c;
        c = (n < 2) ? 0 : (((n - 1) * f) / FR - ((n - 2) * f) / FR);
        return ((d < 2) ? 2 : d) + c;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_d = 27; m_f = 2; m_pend = 0; m_el = 0; m_n = 1; m_tk = 0;
            e_tick = 0; e_baud = 0;
        end else begin
            m_apply = 0; e_tick = 0; e_baud = 0;
            if (!enable) begin
                m_el = 0; m_n = 1; m_tk = 0;
                m_apply = m_pend;
            end else begin
                m_el++;
                if (m_el == plen(m_n, m_d, m_f)) begin
                    e_tick = 1; m_el = 0; m_n++; m_tk++;
                    if (m_tk % OSR == 0) begin
                        e_baud = 1;
                        m_apply = m_pend;
                    end
                end
            end
            if (m_apply) begin
                m_d = s_d; m_f = s_f; m_n = 1;
            end
            if (load) begin
                s_d = int'(div_int); s_f = int'(div_frac); m_pend = 1;
            end else if (m_apply) begin
                m_pend = 0;
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;
    int cyc_no = 0;
    int last_tick = 0;
    int gaps[$];
    int bcyc[$];
    int btick[$];

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc_no++;
            chk("model_tick", tick_os, e_tick);
            chk("model_baud", baud_tick, e_baud);
            chk("model_pend", cfg_pending, m_pend);
            if (tick_os === 1'b1) begin
                gaps.push_back(cyc_no - last_tick);
                last_tick = cyc_no;
            end
            if (baud_tick === 1'b1) begin
                bcyc.push_back(cyc_no);
                btick.push_back(gaps.size());
            end
        end
    endtask

    task automatic do_load(input int d, input int f);
        load = 1'b1; div_int = DIV_W'(d); div_frac = FRAC_W'(f);
        cyc(1);
        load = 1'b0;
    endtask

    task automatic restart_marks();
        gaps.delete(); bcyc.delete(); btick.delete();
        last_tick = cyc_no;
    endtask

    initial begin
        int t0, sum, ok, found;
        reset = 1'b1; enable = 1'b0; load = 1'b0; div_int = '0; div_frac = '0;
        #1;
        chk("rst_tick", tick_os, 1'b0);
        chk("rst_baud", baud_tick, 1'b0);
        chk("rst_pend", cfg_pending, 1'b0);
        cyc(3);

        // Default divisor 27 + 2/16
        reset = 1'b0; enable = 1'b1;
        restart_marks(); t0 = cyc_no;
        cyc(3 * 434 + 10);
        chki("dflt_first", gaps[0], 27);
        chki("dflt_gap7", gaps[7], 27);
        chki("dflt_gap8", gaps[8], 28);
        chki("dflt_gap16", gaps[16], 28);
        chki("dflt_baud0", bcyc[0] - t0, 433);
        chki("dflt_baud_per", bcyc[1] - bcyc[0], 434);

        // Load 10/0 while disabled
        enable = 1'b0; cyc(2);
        do_load(10, 0);
        chk("dis_pend_on", cfg_pending, 1'b1);
        cyc(1);
        chk("dis_pend_off", cfg_pending, 1'b0);
        enable = 1'b1; restart_marks();
        cyc(340);
        chki("int10_gap0", gaps[0], 10);
        chki("int10_gap5", gaps[5], 10);
        chki("int10_baud_per", bcyc[1] - bcyc[0], 160);
        chki("int10_baud_tick16", btick[0], 16);

        // 10 + 8/16
        enable = 1'b0; do_load(10, 8); cyc(1);
        enable = 1'b1; restart_marks();
        cyc(200);
        sum = 0;
        for (int i = 0; i < 16; i++) sum += gaps[i];
        chki("frac8_cum16", sum, 167);
        chki("frac8_gap2", gaps[2], 11);
        chki("frac8_gap3", gaps[3], 10);

        // Mid-bit reloads while running at 10
        enable = 1'b0; do_load(10, 0); cyc(1);
        enable = 1'b1; cyc(50);
        do_load(5, 0); cyc(20);
        do_load(7, 0);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            cyc(1);
            if (baud_tick === 1'b1) found = 1;
        end
        chki("reload_boundary", found, 1);
        chk("reload_pend_clr", cfg_pending, 1'b0);
        restart_marks();
        cyc(40);
        chki("reload_gap0", gaps[0], 7);
        chki("reload_gap3", gaps[3], 7);

        // Degenerate divisors 0 and 1
        enable = 1'b0; do_load(0, 0); cyc(1);
        enable = 1'b1; restart_marks(); cyc(12);
        chki("div0_gap", gaps[1], 2);
        enable = 1'b0; do_load(1, 0); cyc(1);
        enable = 1'b1; restart_marks(); cyc(12);
        chki("div1_gap", gaps[2], 2);

        // Enable dropped mid-period
        enable = 1'b0; do_load(10, 0); cyc(1);
        enable = 1'b1; cyc(25);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            cyc(1);
            if (tick_os === 1'b1) found = 1;
        end
        chki("pause_sync", found, 1);
        cyc(5);
        enable = 1'b0; cyc(3);
        enable = 1'b1; restart_marks();
        cyc(170);
        chki("pause_gap0", gaps[0], 10);
        chki("pause_os_restart", btick[0], 16);

        // Async reset with a load pending
        do_load(40, 3);
        cyc(3);
        @(posedge clk); #2;
        reset = 1'b1; #1;
        chk("arst_tick", tick_os, 1'b0);
        chk("arst_baud", baud_tick, 1'b0);
        chk("arst_pend", cfg_pending, 1'b0);
        cyc(2);
        reset = 1'b0; restart_marks();
        cyc(60);
        chki("arst_gap0", gaps[0], 27);
        chki("arst_gap1", gaps[1], 27);

        // Randomized phase
        ok = 0;
        for (int i = 0; i < 1500; i++) begin
            enable   = ($urandom_range(0, 19) != 0);
            load     = ($urandom_range(0, 29) == 0);
            div_int  = DIV_W'($urandom_range(0, 12));
            div_frac = FRAC_W'($urandom);
            cyc(1);
        end
        load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
Runtime-programmable UART baud generator. It produces an oversample tick and a bit-rate tick from a divisor that has an integer part and a fractional part. A fractional accumulator spreads the remainder cycles, so long-run tick rate error stays below one clock per 2^FRAC_W ticks. It replaces fixed-divisor generation and feeds both the TX shifter (baud_tick) and the RX sampler (tick_os). Divisor changes are shadowed and take effect only on a bit boundary.

Parameters:
DIV_W, 16, width of integer divisor (clocks per oversample tick)
FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W clock)
OSR, 16, oversample ticks per baud_tick; legal range 2..256
RST_DIV_INT, 27, integer divisor loaded at reset (50 MHz / 115200 / 16)
RST_DIV_FRAC, 2, fractional divisor loaded at reset

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
enable  input  1  run when high; clear and hold when low
load  input  1  one-cycle strobe; capture div_int/div_frac into pending shadow
div_int  input  DIV_W  integer divisor; values 0 and 1 are treated as 2
div_frac  input  FRAC_W  fractional divisor numerator
tick_os  output  1  one-cycle pulse at each oversample instant
baud_tick  output  1  one-cycle pulse every OSR tick_os, coincident with the OSR-th one
cfg_pending  output  1  high while a loaded divisor awaits application

Behaviour:
- Reset (async): active divisor = RST_DIV_INT/RST_DIV_FRAC. Cycle counter, frac accumulator, os counter and pending shadow are cleared. tick_os=0, baud_tick=0, cfg_pending=0.
- All outputs are registered.
- Period length: len = max(div_int_active,2) + carry.
  - carry is produced by the previous tick_os update.
  - At each tick_os: {carry, acc} <= acc + div_frac_active, where acc is FRAC_W bits and carry is the overflow.
  - The first period after enable or reset uses carry=0 and acc=0.
- With enable held high, consecutive tick_os pulses are spaced exactly len cycles apart. The first tick_os is asserted in the cycle after the len-th rising edge with enable=1.
- os counter: 0..OSR-1, advances on each tick_os. When tick_os fires with os counter = OSR-1, baud_tick is asserted in the same cycle and the counter wraps to 0.
- enable low: cycle counter, acc, carry and os counter are held at 0; tick_os=0 and baud_tick=0. The active and pending divisors are retained. Deasserting enable mid-period discards the partial period.
- load:
  - Captures div_int/div_frac into the shadow and sets cfg_pending.
  - A second load before application overwrites the shadow; only the last value is applied.
  - The shadow is applied in the cycle baud_tick is asserted. From that point the next period uses the new divisor with acc=0 and carry=0, and cfg_pending clears in the same cycle.
  - If enable is low, the shadow is applied on the cycle after load.
  - If load coincides with the applying baud_tick, the new value stays pending until the next baud_tick.
- Arithmetic: cycle counter is DIV_W+1 bits, so div_int = 2^DIV_W-1 plus carry does not overflow. Accumulator wraps modulo 2^FRAC_W.
- Reset mid-operation: immediate return to reset state; any pending load is lost.

Test Plan:
1. Default after reset, enable=1:
   - tick_os spacing follows 27,27,27,27,27,27,27,28 (repeating; carry every 8th tick with frac=2).
   - baud_tick every 434 cycles: 16*27+2.
   - First tick_os appears 27 edges after enable.
2. div_int=10, div_frac=0, OSR=16 via load with enable=0:
   - Applied next cycle, cfg_pending 1 cycle.
   - After enable: tick_os every 10 cycles; baud_tick every 160, coincident with every 16th tick_os.
3. div_int=10, div_frac=8:
   - Spacing is 10,10,11,10,11,...
   - Cumulative cycles to the 16th tick_os = 167; sustained average 10.5.
4. Load div_int=5 mid-bit while running at div_int=10:
   - cfg_pending stays high until the next baud_tick; no period in between is shortened.
   - After that baud_tick, spacing is 5.
   - A second load (div_int=7) before the boundary leaves 7 as the applied value.
5. div_int=0 and div_int=1: tick_os spacing is 2 cycles.
6. Boundary resets:
   - Deassert enable at cycle 6 of a 10-cycle period, reassert 3 cycles later: the next tick_os is 10 cycles later and the os counter restarts from 0.
   - Assert reset mid-period with a load pending: all outputs drop to 0 asynchronously; after release the RST divisor is active and cfg_pending=0.
